program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake, with a 16-bit word-count header followed by big-endian 32-bit instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses from 0.
- Holds the processor out of execution (cpu_run low) until the full image is written, then releases it.

Parameters:
- DEPTH, 66: instruction memory size in words; headers with a larger count are rejected.
- TIMEOUT, 1024: maximum idle cycles between accepted bytes while a load is in progress; 0 disables the timeout.

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: reset. Asynchronous, active-low.
- start  in  1: single-cycle pulse that begins a load.
- byte_valid  in  1: upstream byte present.
- byte_data  in  8: upstream byte.
- byte_ready  out  1: loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
- im_we  out  1: instruction memory write strobe.
- im_addr  out  32: word-aligned byte address (word_idx<<2).
- im_wdata  out  32: assembled instruction word.
- cpu_run  out  1: high means the processor may fetch and execute.
- busy  out  1: load in progress.
- done  out  1: image loaded successfully.
- error  out  1: load rejected or timed out.
- words_loaded  out  16: count of words written so far in the current load.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including byte_ready, im_we and cpu_run. Any partial word is discarded.
- IDLE: byte_ready=0. start=1 moves to LEN_HI and clears len, byte_idx, word_idx, done and error.
- LEN_HI: byte_ready=1, busy=1. On transfer, len[15:8] is captured and the state moves to LEN_LO.
- LEN_LO: byte_ready=1. On transfer, len[7:0] is captured.
  - len==0 goes to DONE.
  - len>DEPTH goes to ERROR.
  - Otherwise goes to DATA.
- DATA: byte_ready=1. Bytes shift in MSB first (word = {word[23:0], byte}). byte_idx counts 0..3 and wraps to 0.
- Write timing: on the transfer of the 4th byte, the next cycle has im_we=1 for exactly one cycle, with im_addr=word_idx<<2 and im_wdata=the assembled word. word_idx and words_loaded increment in that same cycle.
- Latency is 1 cycle from the 4th-byte handshake to im_we.
- byte_ready stays high during the write cycle; a byte accepted then belongs to the next word.
- im_addr and im_wdata hold their last values when im_we=0.
- After the write that makes word_idx==len, the state moves to DONE on the following edge. Bytes beyond len are not accepted (byte_ready=0).
- DONE: done=1, cpu_run=1, busy=0, byte_ready=0. start=1 restarts the load: next state LEN_HI, with cpu_run and done going 0 at that edge.
- ERROR: error=1, cpu_run=0, byte_ready=0. start=1 restarts the load as from IDLE.
- start is ignored in LEN_HI, LEN_LO and DATA; there is no mid-load restart.
- Timeout: in LEN_HI, LEN_LO and DATA, an idle counter resets on every transfer and increments otherwise. When it reaches TIMEOUT (TIMEOUT>0), the state moves to ERROR; no further im_we is issued and words_loaded holds its value.
- Simultaneous 4th-byte transfer and timeout expiry in the same cycle: the transfer wins and the counter clears.
- words_loaded is 16-bit; DEPTH is at most 65535, so it cannot wrap.
- cpu_run=1 only in DONE.

Decomposition:
- Shared package loader_pkg contains:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR);
  - HDR_W=16;
  - BYTES_PER_WORD=4.
- One sub-module, byte_packer: the shift register plus 2-bit byte counter, emitting word_valid for one cycle with the assembled word. It is cleared by rst_n and by a synchronous clr from the FSM.

Test Plan:
- Reset: hold rst_n=0 mid-simulation -> all outputs 0 immediately (async), state IDLE.
- Normal load: start, then bytes 00 02 20 08 00 05 AC 08 00 04 -> im_we pulses twice: addr 0x0 data 0x20080005, then addr 0x4 data 0xAC080004. Then done=1, cpu_run=1, words_loaded=2, byte_ready=0.
- Empty and oversize headers:
  - Header 00 00 -> DONE with no im_we.
  - Header 00 43 (67 > DEPTH) -> error=1, cpu_run=0, no im_we.
- Backpressure and timeout (TIMEOUT=16):
  - Random byte_valid gaps under 16 cycles -> identical writes to the normal load.
  - A 16-cycle gap after the 2nd data byte -> error=1 with words_loaded unchanged.
  - A following start plus a full stream -> successful DONE.
- Start ignored: pulse start during DATA after 5 bytes -> no restart; writes and addresses are unchanged.
- Mid-load reset: assert rst_n=0 after 6 data bytes -> no further im_we, cpu_run=0. A fresh start plus a 1-word image 00 01 12 34 56 78 -> write at addr 0x0 with data 0x12345678, then done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding, header width and word geometry used by the
// loader top, its byte packer and its interface.
package loader_pkg;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's start/byte-stream inputs and its instruction-memory
// and status outputs. The master modport is the stream source / system side;
// the slave modport is the loader itself.
interface program_loader_if;
    import loader_pkg::*;

    logic                 start;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 im_we;
    logic [31:0]          im_addr;
    logic [WORD_W-1:0]    im_wdata;
    logic                 cpu_run;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [HDR_W-1:0]     words_loaded;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata,
        input  cpu_run, busy, done, error, words_loaded
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata,
        output cpu_run, busy, done, error, words_loaded
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Assembles big-endian instruction words from accepted bytes (MSB first).
// Latency: o_word_vld is combinational with the 4th accepted byte.
// Backpressure: none of its own; i_en is the accepted-byte strobe from the FSM.
// Ports: clk/rst_n, i_clr (sync clear), i_en, i_byte -> o_word_vld, o_word.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [7:0]        i_byte,
    output logic              o_word_vld,
    output logic [WORD_W-1:0] o_word
);

    localparam int SHIFT_W = WORD_W - 8;

    logic [SHIFT_W-1:0] r_shift;
    logic [1:0]         r_idx;

    // The final byte completes the word on the same cycle it is accepted,
    // so the top can register the write with a single cycle of latency.
    assign o_word     = {r_shift, i_byte};
    assign o_word_vld = i_en && (r_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[SHIFT_W-9:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a 16-bit word-count header then writes big-endian words
// to instruction memory from address 0, releasing cpu_run once complete.
// Latency: im_we one cycle after the 4th byte of a word is accepted.
// Backpressure: byte_ready low outside the header/data phases and once all
// words of the image have been accepted.
// Ports: clk, rst_n, bus (program_loader_if.slave).
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH   = 66,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    program_loader_if.slave   bus
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LEN_HI = LEN_HI;
    localparam logic [2:0] ST_LEN_LO = LEN_LO;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_DONE   = DONE;
    localparam logic [2:0] ST_ERROR  = ERROR;

    logic [2:0]        r_state;
    logic [HDR_W-1:0]  r_len;
    logic [HDR_W-1:0]  r_word_idx;
    logic [31:0]       r_idle;
    logic              r_im_we;
    logic [31:0]       r_im_addr;
    logic [WORD_W-1:0] r_im_wdata;

    logic              w_byte_ready;
    logic              w_xfer;
    logic              w_restart;
    logic              w_data_xfer;
    logic              w_timeout;
    logic              w_word_vld;
    logic [WORD_W-1:0] w_word;
    logic [HDR_W-1:0]  w_len_full;

    // In DATA, once every word has been taken (word_idx==len) no more bytes
    // are accepted; this covers the final write cycle before DONE.
    assign w_byte_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                          ((r_state == ST_DATA) && (r_word_idx != r_len));
    assign w_xfer       = bus.byte_valid && w_byte_ready;
    assign w_restart    = bus.start && ((r_state == ST_IDLE) ||
                          (r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_data_xfer  = w_xfer && (r_state == ST_DATA);
    assign w_len_full   = {r_len[HDR_W-1:8], bus.byte_data};
    // Fires on the idle cycle that would bring the counter to TIMEOUT.
    assign w_timeout    = (TIMEOUT != 32'd0) && (r_idle == (TIMEOUT - 32'd1));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_restart),
        .i_en       (w_data_xfer),
        .i_byte     (bus.byte_data),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_idle     <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        r_state    <= ST_LEN_HI;
                        r_len      <= '0;
                        r_word_idx <= '0;
                        r_idle     <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[HDR_W-1:8] <= bus.byte_data;
                        r_idle           <= '0;
                        r_state          <= ST_LEN_LO;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len  <= w_len_full;
                        r_idle <= '0;
                        if (w_len_full == '0)
                            r_state <= ST_DONE;
                        else if (32'(w_len_full) > DEPTH)
                            r_state <= ST_ERROR;
                        else
                            r_state <= ST_DATA;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (r_word_idx == r_len) begin
                        r_state <= ST_DONE;
                    end else if (w_xfer) begin
                        // A completing byte beats a simultaneous timeout.
                        r_idle <= '0;
                        if (w_word_vld) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= {{(32-HDR_W-2){1'b0}}, r_word_idx, 2'b00};
                            r_im_wdata <= w_word;
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready   = w_byte_ready;
    assign bus.im_we        = r_im_we;
    assign bus.im_addr      = r_im_addr;
    assign bus.im_wdata     = r_im_wdata;
    assign bus.cpu_run      = (r_state == ST_DONE);
    assign bus.busy         = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                              (r_state == ST_DATA);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.error        = (r_state == ST_ERROR);
    assign bus.words_loaded = r_word_idx;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized images
// compared against a header/word-list reference model of the load protocol.
// Ports: none (instantiates program_loader_if and program_loader).
`timescale 1ns/1ps
module tb_program_loader;
    import loader_pkg::*;

    localparam int unsigned DEPTH   = 66;
    localparam int unsigned TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if ifc ();

    program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stim[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_data[$];
    logic        exp_error;
    int unsigned exp_words;

    // Capture every instruction-memory write seen mid-cycle.
    always @(negedge clk) begin
        if (ifc.im_we === 1'b1) begin
            got_addr.push_back(ifc.im_addr);
            got_data.push_back(ifc.im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: header gives word count; words are big-endian groups
    // of four bytes; zero count is an empty image, count above DEPTH rejected.
    function automatic void build_expect();
        int unsigned len;
        exp_data.delete();
        len = {stim[0], stim[1]};
        if (len == 0) begin
            exp_error = 1'b0; exp_words = 0;
        end else if (len > DEPTH) begin
            exp_error = 1'b1; exp_words = 0;
        end else begin
            exp_error = 1'b0; exp_words = len;
            for (int w = 0; w < int'(len); w++)
                exp_data.push_back({stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]});
        end
    endfunction

    task automatic make_image(input int unsigned len, input int unsigned nwords);
        stim.delete();
        stim.push_back(len[15:8]);
        stim.push_back(len[7:0]);
        for (int i = 0; i < int'(nwords) * 4; i++)
            stim.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        ifc.byte_valid = 1'b1;
        ifc.byte_data  = b;
        while (ifc.byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ifc.byte_ready !== 1'b1) check("byte_ready_wait", {31'd0, ifc.byte_ready}, 32'd1);
        else @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ifc.byte_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.byte_valid = 1'b0;
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic stream_from(input int first, input int max_gap);
        for (int i = first; i < stim.size(); i++) begin
            if (max_gap > 0) begin
                int g;
                g = int'($urandom_range(max_gap, 0));
                if (g > 0) idle(g);
            end
            send_byte(stim[i]);
        end
        idle(1);
    endtask

    task automatic wait_end();
        int n = 0;
        #1;
        while (ifc.done !== 1'b1 && ifc.error !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_nwr"}, got_data.size(), exp_data.size());
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            check({tag, "_addr"}, got_addr[i], 32'(i * 4));
            check({tag, "_data"}, got_data[i], exp_data[i]);
        end
        check({tag, "_done"},  {31'd0, ifc.done},       {31'd0, ~exp_error});
        check({tag, "_error"}, {31'd0, ifc.error},      {31'd0, exp_error});
        check({tag, "_run"},   {31'd0, ifc.cpu_run},    {31'd0, ~exp_error});
        check({tag, "_busy"},  {31'd0, ifc.busy},       32'd0);
        check({tag, "_rdy"},   {31'd0, ifc.byte_ready}, 32'd0);
        check({tag, "_words"}, {16'd0, ifc.words_loaded}, exp_words);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    {31'd0, ifc.im_we},      32'd0);
        check({tag, "_rdy"},   {31'd0, ifc.byte_ready}, 32'd0);
        check({tag, "_run"},   {31'd0, ifc.cpu_run},    32'd0);
        check({tag, "_busy"},  {31'd0, ifc.busy},       32'd0);
        check({tag, "_done"},  {31'd0, ifc.done},       32'd0);
        check({tag, "_error"}, {31'd0, ifc.error},      32'd0);
        check({tag, "_words"}, {16'd0, ifc.words_loaded}, 32'd0);
        check({tag, "_addr"},  ifc.im_addr,  32'd0);
        check({tag, "_wdata"}, ifc.im_wdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.start      = 1'b0;
        ifc.byte_valid = 1'b0;
        ifc.byte_data  = 8'h00;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed two-word image with a latency probe on the first word.
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        build_expect();
        clear_got();
        pulse_start();
        check("start_busy", {31'd0, ifc.busy}, 32'd1);
        for (int i = 0; i < 6; i++) send_byte(stim[i]);
        #1;
        check("lat_we",    {31'd0, ifc.im_we}, 32'd1);
        check("lat_addr",  ifc.im_addr,  32'h0);
        check("lat_wdata", ifc.im_wdata, 32'h20080005);
        check("lat_words", {16'd0, ifc.words_loaded}, 32'd1);
        stream_from(6, 0);
        wait_end();
        check_result("normal");
        check("normal_w1", got_data.size() > 1 ? got_data[1] : 32'hDEAD, 32'hAC080004);
        check("hold_addr",  ifc.im_addr,  32'h4);
        check("hold_wdata", ifc.im_wdata, 32'hAC080004);

        // Empty header, restarted straight from DONE.
        stim = '{8'h00, 8'h00};
        build_expect();
        clear_got();
        pulse_start();
        check("restart_run",  {31'd0, ifc.cpu_run}, 32'd0);
        check("restart_done", {31'd0, ifc.done},    32'd0);
        check("restart_busy", {31'd0, ifc.busy},    32'd1);
        stream_from(0, 0);
        wait_end();
        check_result("empty");

        // Oversize header: one past DEPTH.
        stim = '{8'h00, 8'h43};
        build_expect();
        clear_got();
        pulse_start();
        stream_from(0, 0);
        wait_end();
        check_result("oversize");

        // Randomized images with sub-timeout gaps.
        for (int t = 0; t < 4; t++) begin
            int unsigned n;
            n = $urandom_range(5, 1);
            make_image(n, n);
            build_expect();
            clear_got();
            pulse_start();
            stream_from(0, 12);
            wait_end();
            check_result("rand");
        end
        begin
            int unsigned n;
            n = $urandom_range(65535, DEPTH + 1);
            make_image(n, 0);
            build_expect();
            clear_got();
            pulse_start();
            stream_from(0, 5);
            wait_end();
            check_result("rand_over");
        end

        // Timeout after the 2nd data byte: 15 idle cycles survive, 16 do not.
        make_image(2, 2);
        clear_got();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        idle(15);
        #1;
        check("to_15_error", {31'd0, ifc.error}, 32'd0);
        check("to_15_busy",  {31'd0, ifc.busy},  32'd1);
        idle(1);
        #1;
        check("to_16_error", {31'd0, ifc.error},   32'd1);
        check("to_16_run",   {31'd0, ifc.cpu_run}, 32'd0);
        check("to_16_words", {16'd0, ifc.words_loaded}, 32'd0);
        check("to_16_nwr",   got_data.size(), 32'd0);
        make_image(3, 3);
        build_expect();
        clear_got();
        pulse_start();
        stream_from(0, 10);
        wait_end();
        check_result("after_to");

        // start during DATA is ignored.
        make_image(2, 2);
        build_expect();
        clear_got();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stim[i]);
        pulse_start();
        check("ign_busy",  {31'd0, ifc.busy}, 32'd1);
        check("ign_words", {16'd0, ifc.words_loaded}, 32'd1);
        stream_from(7, 0);
        wait_end();
        check_result("ignore");

        // Reset in the middle of a load, then a fresh one-word image.
        make_image(3, 3);
        build_expect();
        clear_got();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(stim[i]);
        #2 rst_n = 1'b0;
        ifc.byte_valid = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (5) @(posedge clk);
        #1;
        check("midrst_nwr", got_data.size(), 32'd1);
        check("midrst_w0",  got_data.size() > 0 ? got_data[0] : 32'hDEAD, exp_data[0]);
        @(negedge clk) rst_n = 1'b1;
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        build_expect();
        clear_got();
        pulse_start();
        stream_from(0, 0);
        wait_end();
        check_result("after_rst");
        check("after_rst_w0", got_data.size() > 0 ? got_data[0] : 32'hDEAD, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
